// File: rtl/mem_dma.sv
// mem_dma: word-copy DMA engine for the picorv32 native memory bus.
// Register responder (SRC/DST/LEN/CTRL) plus a read-then-write bus initiator.
// Optional fill mode (CTRL.FILL) is built only when DMA_FILL_EN is defined.
//
// state | meaning
// IDLE  | waiting for START
// RD    | read request at working src, held until mem_ready
// GAP_R | one idle bus cycle after the read
// WR    | write request at working dst, held until mem_ready
// GAP_W | one idle bus cycle; finish or launch the next word
module mem_dma #(
   parameter int LEN_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        select,
   input  logic [3:0]  wstrb,
   input  logic [3:0]  addr,
   input  logic [31:0] data_i,
   output logic        ready,
   output logic [31:0] data_o,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        irq
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP_R, S_WR, S_GAP_W} state_t;

   state_t               state;
   logic [31:0]          src_reg, dst_reg;
   logic [LEN_WIDTH-1:0] len_reg;
   logic                 done_reg, ien_reg;
   logic [31:0]          src_w, dst_w, buf_w;
   logic [LEN_WIDTH-1:0] cnt_w;
   logic                 busy, reg_acc, reg_wr, start_req;
   logic [31:0]          rdata, ctrl_rd;
   logic                 fill_cfg, fill_mode;
   logic                 unused_addr;

`ifdef DMA_FILL_EN
   logic fill_reg;
   logic fill_run;
   assign fill_cfg  = fill_reg;
   assign fill_mode = fill_run;
`else
   assign fill_cfg  = 1'b0;
   assign fill_mode = 1'b0;
`endif

   assign busy        = (state != S_IDLE);
   assign reg_acc     = select && !ready;
   assign reg_wr      = reg_acc && (|wstrb);
   assign start_req   = reg_wr && (addr[3:2] == 2'd3) && data_i[0];
   assign ctrl_rd     = {27'h0, fill_cfg, ien_reg, done_reg, busy, 1'b0};
   assign irq         = done_reg && ien_reg;
   assign unused_addr = ^addr[1:0];

   // Register read mux
   always_comb begin
      rdata = 32'h0;
      case (addr[3:2])
         2'd0:    rdata = src_reg;
         2'd1:    rdata = dst_reg;
         2'd2:    rdata = {{(32-LEN_WIDTH){1'b0}}, len_reg};
         default: rdata = ctrl_rd;
      endcase
   end

   // Register port handshake: one-cycle ready pulse with read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready  <= 1'b0;
         data_o <= 32'h0;
      end else begin
         ready  <= reg_acc;
         data_o <= reg_acc ? rdata : 32'h0;
      end
   end

   // Register writes and transfer FSM; DONE set is last so it wins over a clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         src_reg   <= 32'h0;
         dst_reg   <= 32'h0;
         len_reg   <= '0;
         done_reg  <= 1'b0;
         ien_reg   <= 1'b0;
         src_w     <= 32'h0;
         dst_w     <= 32'h0;
         buf_w     <= 32'h0;
         cnt_w     <= '0;
         mem_valid <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_wstrb <= 4'h0;
`ifdef DMA_FILL_EN
         fill_reg  <= 1'b0;
         fill_run  <= 1'b0;
`endif
      end else begin
         if (reg_wr) begin
            case (addr[3:2])
               2'd0: if (!busy) src_reg <= {data_i[31:2], 2'b00};
               2'd1: if (!busy) dst_reg <= {data_i[31:2], 2'b00};
               2'd2: if (!busy) len_reg <= data_i[LEN_WIDTH-1:0];
               default: begin
                  ien_reg <= data_i[3];
                  if (data_i[2]) done_reg <= 1'b0;
`ifdef DMA_FILL_EN
                  fill_reg <= data_i[4];
`endif
               end
            endcase
         end

         case (state)
            S_IDLE: begin
               if (start_req) begin
                  if (len_reg == '0) begin
                     done_reg <= 1'b1;
                  end else begin
                     src_w     <= src_reg;
                     dst_w     <= dst_reg;
                     cnt_w     <= len_reg;
                     mem_valid <= 1'b1;
`ifdef DMA_FILL_EN
                     fill_run  <= fill_reg;
`endif
                     if (fill_cfg) begin
                        // Fill pattern is the SRC register itself
                        buf_w     <= src_reg;
                        mem_addr  <= dst_reg;
                        mem_wdata <= src_reg;
                        mem_wstrb <= 4'hF;
                        state     <= S_WR;
                     end else begin
                        mem_addr  <= src_reg;
                        mem_wstrb <= 4'h0;
                        state     <= S_RD;
                     end
                  end
               end
            end
            S_RD: begin
               if (mem_ready) begin
                  buf_w     <= mem_rdata;
                  mem_valid <= 1'b0;
                  state     <= S_GAP_R;
               end
            end
            S_GAP_R: begin
               mem_valid <= 1'b1;
               mem_addr  <= dst_w;
               mem_wdata <= buf_w;
               mem_wstrb <= 4'hF;
               state     <= S_WR;
            end
            S_WR: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  mem_wstrb <= 4'h0;
                  if (!fill_mode) src_w <= src_w + 32'd4;
                  dst_w     <= dst_w + 32'd4;
                  cnt_w     <= cnt_w - LEN_WIDTH'(1);
                  state     <= S_GAP_W;
               end
            end
            S_GAP_W: begin
               if (cnt_w == '0) begin
                  done_reg <= 1'b1;
                  state    <= S_IDLE;
               end else if (fill_mode) begin
                  mem_valid <= 1'b1;
                  mem_addr  <= dst_w;
                  mem_wdata <= buf_w;
                  mem_wstrb <= 4'hF;
                  state     <= S_WR;
               end else begin
                  mem_valid <= 1'b1;
                  mem_addr  <= src_w;
                  mem_wstrb <= 4'h0;
                  state     <= S_RD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: directed register programming, scoreboard of expected bus
// requests checked by an independent monitor, plus a small memory slave.
module tb_mem_dma;

   localparam logic [3:0] A_SRC = 4'h0, A_DST = 4'h4, A_LEN = 4'h8, A_CTRL = 4'hC;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        select = 1'b0;
   logic [3:0]  wstrb = 4'h0;
   logic [3:0]  reg_addr = 4'h0;
   logic [31:0] data_i = 32'h0;
   logic        ready;
   logic [31:0] data_o;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        irq;

   always #5 clk = ~clk;

   mem_dma #(.LEN_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .select(select), .wstrb(wstrb), .addr(reg_addr),
      .data_i(data_i), .ready(ready), .data_o(data_o), .mem_valid(mem_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .irq(irq)
   );

   // ---------------- memory slave with programmable wait states
   logic [31:0] mem [0:255];
   int          wait_cfg = 0;
   int          wcnt;
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx = 8'h0;
   logic [31:0] pl_data = 32'h0;

   assign mem_ready = mem_valid && (wcnt == wait_cfg);
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wcnt <= 0;
      end else begin
         if (pl_en) mem[pl_idx] <= pl_data;
         if (mem_valid && mem_ready) begin
            wcnt <= 0;
            if (mem_wstrb == 4'hF) mem[mem_addr[9:2]] <= mem_wdata;
         end else if (mem_valid) begin
            wcnt <= wcnt + 1;
         end
      end
   end

   // ---------------- scoreboard
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } bus_t;
   typedef struct packed {
      logic [31:0] data;
      logic        chk;
   } rd_t;

   bus_t bus_q[$];
   rd_t  reg_q[$];
   rd_t  cur_rd;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   hs_cnt = 0;
   logic prev_hs = 1'b0;
   logic prev_rdy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, {31'h0, act}, {31'h0, exp});
   endtask

   // Monitor: compare every bus request cycle against the queue head, pop on handshake
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_hs  = 1'b0;
         prev_rdy = 1'b0;
      end else begin
         if (prev_hs) chk1("valid_after_ready", mem_valid, 1'b0);
         if (mem_valid) begin
            if (bus_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL bus_unexpected: got addr %h wstrb %h, expected no request", mem_addr, mem_wstrb);
            end else begin
               chk("bus_addr", mem_addr, bus_q[0].addr);
               chk("bus_wstrb", {28'h0, mem_wstrb}, {28'h0, bus_q[0].wstrb});
               if (bus_q[0].wstrb == 4'hF) chk("bus_wdata", mem_wdata, bus_q[0].wdata);
               if (mem_ready) begin
                  void'(bus_q.pop_front());
                  hs_cnt++;
               end
            end
         end
         prev_hs = mem_valid && mem_ready;

         if (prev_rdy) chk1("ready_pulse", ready, 1'b0);
         if (ready) begin
            if (reg_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL reg_ready_unexpected: got ready=1, expected 0");
            end else begin
               cur_rd = reg_q.pop_front();
               if (cur_rd.chk) chk("reg_read", data_o, cur_rd.data);
            end
         end
         prev_rdy = ready;
      end
   end

   // ---------------- stimulus helpers
   task automatic reg_access(input logic [3:0] a, input logic [31:0] d, input logic wr,
                             input logic [31:0] exp, input logic do_chk);
      @(negedge clk);
      select   = 1'b1;
      reg_addr = a;
      wstrb    = wr ? 4'hF : 4'h0;
      data_i   = d;
      reg_q.push_back('{data: exp, chk: do_chk});
      @(negedge clk);
      select = 1'b0;
      wstrb  = 4'h0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      reg_access(a, d, 1'b1, 32'h0, 1'b0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      reg_access(a, 32'h0, 1'b0, exp, 1'b1);
   endtask

   task automatic push_bus(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] d);
      bus_q.push_back('{addr: a, wstrb: ws, wdata: d});
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1;
      pl_idx = idx;
      pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic wait_bus_empty(input int max, input string nm);
      int i = 0;
      while (bus_q.size() != 0 && i < max) begin
         @(negedge clk);
         i++;
      end
      chk({nm, "_outstanding"}, bus_q.size(), 32'd0);
      bus_q.delete();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      int i;

      // ---- reset values
      repeat (3) @(negedge clk);
      chk1("rst_ready", ready, 1'b0);
      chk("rst_data_o", data_o, 32'h0);
      chk1("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
      chk1("rst_irq", irq, 1'b0);
      reset_n = 1'b1;

      for (int k = 0; k < 4; k++) preload(8'(k), 32'h11 * (k + 1));
      preload(8'h04, 32'hDEAD_0001);
      preload(8'h05, 32'hDEAD_0002);
      for (int k = 0; k < 3; k++) preload(8'(8 + k), 32'h0B0B_0001 + k);
      preload(8'hFF, 32'hCAFE_0FFF);

      rd(A_SRC, 32'h0);
      rd(A_DST, 32'h0);
      rd(A_LEN, 32'h0);
      rd(A_CTRL, 32'h0);

      // ---- basic copy, zero-wait slave
      wr(A_SRC, 32'h0002_0000);
      wr(A_DST, 32'h0002_0100);
      wr(A_LEN, 32'd4);
      for (int k = 0; k < 4; k++) begin
         push_bus(32'h0002_0000 + 4 * k, 4'h0, 32'h0);
         push_bus(32'h0002_0100 + 4 * k, 4'hF, 32'h11 * (k + 1));
      end
      hs0 = hs_cnt;
      wr(A_CTRL, 32'h1);
      chk1("start_latency", mem_valid, 1'b1);
      repeat (14) @(negedge clk);
      rd(A_CTRL, 32'h2);   // sampled at clock 16 before DONE lands: still BUSY
      rd(A_CTRL, 32'h4);   // DONE, not BUSY
      chk("copy_txn_count", hs_cnt - hs0, 32'd8);
      chk1("copy_irq", irq, 1'b0);
      for (int k = 0; k < 4; k++) chk("copy_mem", mem[8'h40 + k], 32'h11 * (k + 1));
      rd(A_SRC, 32'h0002_0000);
      rd(A_LEN, 32'd4);
      wr(A_CTRL, 32'h4);
      rd(A_CTRL, 32'h0);

      // ---- wait states
      wait_cfg = 3;
      wr(A_SRC, 32'h0002_0010);
      wr(A_DST, 32'h0002_0200);
      wr(A_LEN, 32'd2);
      push_bus(32'h0002_0010, 4'h0, 32'h0);
      push_bus(32'h0002_0200, 4'hF, 32'hDEAD_0001);
      push_bus(32'h0002_0014, 4'h0, 32'h0);
      push_bus(32'h0002_0204, 4'hF, 32'hDEAD_0002);
      wr(A_CTRL, 32'h1);
      wait_bus_empty(200, "wait_states");
      rd(A_CTRL, 32'h4);
      chk("wait_mem0", mem[8'h80], 32'hDEAD_0001);
      chk("wait_mem1", mem[8'h81], 32'hDEAD_0002);
      wr(A_CTRL, 32'h4);
      wait_cfg = 0;

      // ---- LEN=0 with IEN
      wr(A_LEN, 32'd0);
      hs0 = hs_cnt;
      wr(A_CTRL, 32'h9);
      chk1("len0_irq", irq, 1'b1);
      chk1("len0_no_valid", mem_valid, 1'b0);
      rd(A_CTRL, 32'hC);
      chk("len0_txn_count", hs_cnt - hs0, 32'd0);
      wr(A_CTRL, 32'h4);
      chk1("done_clear_irq", irq, 1'b0);
      rd(A_CTRL, 32'h0);
      wr(A_CTRL, 32'h9);
      chk1("len0_irq2", irq, 1'b1);
      wr(A_CTRL, 32'h0);
      chk1("ien_clear_irq", irq, 1'b0);
      rd(A_CTRL, 32'h4);
      wr(A_CTRL, 32'h4);

      // ---- busy protection
      wr(A_SRC, 32'h0002_0020);
      wr(A_DST, 32'h0002_0300);
      wr(A_LEN, 32'd3);
      for (int k = 0; k < 3; k++) begin
         push_bus(32'h0002_0020 + 4 * k, 4'h0, 32'h0);
         push_bus(32'h0002_0300 + 4 * k, 4'hF, 32'h0B0B_0001 + k);
      end
      wr(A_CTRL, 32'h1);
      wr(A_DST, 32'h0);
      wr(A_SRC, 32'h0);
      wr(A_LEN, 32'd7);
      wr(A_CTRL, 32'h1);
      rd(A_SRC, 32'h0002_0020);
      rd(A_DST, 32'h0002_0300);
      rd(A_LEN, 32'd3);
      wait_bus_empty(200, "busy");
      rd(A_CTRL, 32'h4);
      for (int k = 0; k < 3; k++) chk("busy_mem", mem[8'hC0 + k], 32'h0B0B_0001 + k);
      wr(A_CTRL, 32'h4);

      // ---- exact completion timing via irq (LEN=1)
      wr(A_SRC, 32'h0002_0000);
      wr(A_DST, 32'h0002_0380);
      wr(A_LEN, 32'd1);
      push_bus(32'h0002_0000, 4'h0, 32'h0);
      push_bus(32'h0002_0380, 4'hF, 32'h11);
      wr(A_CTRL, 32'h9);
      repeat (3) @(negedge clk);
      chk1("irq_before_done", irq, 1'b0);
      @(negedge clk);
      chk1("irq_at_done", irq, 1'b1);
      wait_bus_empty(50, "timing");
      wr(A_CTRL, 32'h4);
      chk1("irq_cleared", irq, 1'b0);

      // ---- DONE clear in the completion cycle: set wins
      wr(A_DST, 32'h0002_0384);
      push_bus(32'h0002_0000, 4'h0, 32'h0);
      push_bus(32'h0002_0384, 4'hF, 32'h11);
      wr(A_CTRL, 32'h1);
      repeat (2) @(negedge clk);
      wr(A_CTRL, 32'h4);
      rd(A_CTRL, 32'h4);
      wr(A_CTRL, 32'h4);
      rd(A_CTRL, 32'h0);

      // ---- address wrap at 2^32
      wr(A_SRC, 32'hFFFF_FFFC);
      wr(A_DST, 32'h0002_03F0);
      wr(A_LEN, 32'd2);
      push_bus(32'hFFFF_FFFC, 4'h0, 32'h0);
      push_bus(32'h0002_03F0, 4'hF, 32'hCAFE_0FFF);
      push_bus(32'h0000_0000, 4'h0, 32'h0);
      push_bus(32'h0002_03F4, 4'hF, 32'h11);
      wr(A_CTRL, 32'h1);
      wait_bus_empty(100, "wrap");
      rd(A_CTRL, 32'h4);
      chk("wrap_mem0", mem[8'hFC], 32'hCAFE_0FFF);
      chk("wrap_mem1", mem[8'hFD], 32'h11);
      wr(A_CTRL, 32'h4);

      // ---- fill configuration
`ifdef DMA_FILL_EN
      wr(A_CTRL, 32'h10);
      rd(A_CTRL, 32'h10);
      wr(A_SRC, 32'hA5A5_A5A5);   // low two bits are cleared by the register
      wr(A_DST, 32'h0002_0000);
      wr(A_LEN, 32'd3);
      for (int k = 0; k < 3; k++) push_bus(32'h0002_0000 + 4 * k, 4'hF, 32'hA5A5_A5A4);
      hs0 = hs_cnt;
      wr(A_CTRL, 32'h11);
      repeat (4) @(negedge clk);
      rd(A_CTRL, 32'h12);
      rd(A_CTRL, 32'h14);
      chk("fill_txn_count", hs_cnt - hs0, 32'd3);
      for (int k = 0; k < 3; k++) chk("fill_mem", mem[8'(k)], 32'hA5A5_A5A4);
      wr(A_CTRL, 32'h4);
`else
      wr(A_CTRL, 32'h10);
      rd(A_CTRL, 32'h0);
      wr(A_SRC, 32'h0002_0004);
      wr(A_DST, 32'h0002_0388);
      wr(A_LEN, 32'd1);
      push_bus(32'h0002_0004, 4'h0, 32'h0);
      push_bus(32'h0002_0388, 4'hF, 32'h22);
      wr(A_CTRL, 32'h11);
      wait_bus_empty(50, "nofill");
      rd(A_CTRL, 32'h4);
      chk("nofill_mem", mem[8'hE2], 32'h22);
      wr(A_CTRL, 32'h4);
`endif

      // ---- reset in the middle of a write
      wait_cfg = 5;
      wr(A_SRC, 32'h0002_0004);
      wr(A_DST, 32'h0002_0390);
      wr(A_LEN, 32'd3);
      push_bus(32'h0002_0004, 4'h0, 32'h0);
      push_bus(32'h0002_0390, 4'hF, 32'h22);
      wr(A_CTRL, 32'h1);
      i = 0;
      while (!(mem_valid && mem_wstrb == 4'hF) && i < 50) begin
         @(negedge clk);
         i++;
      end
      chk1("reset_reached_wr", mem_valid && (mem_wstrb == 4'hF), 1'b1);
      #1 reset_n = 1'b0;
      #1 chk1("async_reset_valid", mem_valid, 1'b0);
      bus_q.delete();
      repeat (2) @(negedge clk);
      wait_cfg = 0;
      reset_n = 1'b1;
      rd(A_SRC, 32'h0);
      rd(A_DST, 32'h0);
      rd(A_LEN, 32'h0);
      rd(A_CTRL, 32'h0);
      repeat (3) @(negedge clk);
      chk1("post_reset_idle", mem_valid, 1'b0);

      chk("end_bus_q", bus_q.size(), 32'd0);
      chk("end_reg_q", reg_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
